note_spawn_scheduler: RTL

//  Sequences note spawning for the dance game: paces spawns off the frame tick and draws a lane

---
 rtl/note_spawn_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/note_spawn_scheduler.sv
// Note spawn scheduler: paces lane spawns off the frame tick, picks lanes from the LFSR word
// and ramps difficulty. Optional chord spawning is compiled in with `define DOUBLE_NOTE_EN.
module note_spawn_scheduler #(
  parameter int BASE_INTERVAL  = 60,
  parameter int MIN_INTERVAL   = 12,
  parameter int STEP           = 4,
  parameter int SPAWNS_PER_LVL = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Tick,
  input  logic [9:0]  Rand,
  input  logic        SpawnReady,
  output logic        SpawnValid,
  output logic [3:0]  SpawnMask,
  output logic        Playing,
  output logic [2:0]  Level,
  output logic [7:0]  Interval,
  output logic [15:0] SpawnCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam int          LVL_BITS        = (SPAWNS_PER_LVL > 1) ? $clog2(SPAWNS_PER_LVL) : 1;
  localparam logic [7:0]  BASE_I          = 8'(BASE_INTERVAL);
  localparam logic [7:0]  MIN_I           = 8'(MIN_INTERVAL);
  localparam logic [7:0]  STEP_I          = 8'(STEP);
  localparam logic [8:0]  FLOOR_PLUS_STEP = 9'(MIN_INTERVAL + STEP);

  state_t      state;
  logic [7:0]  countdown;
  logic [1:0]  last_lane;

  logic [15:0] count_inc;
  logic        level_up;
  logic [7:0]  interval_dn;
  logic [7:0]  interval_nx;
  logic [2:0]  level_nx;
  logic [1:0]  lane_raw;
  logic [1:0]  lane_sel;
  logic [3:0]  mask_sel;

  // Handshake: SpawnValid is raised on entry to ISSUE with SpawnMask held constant; the
  // spawn is consumed in the cycle where SpawnValid && SpawnReady, and only Stop or Reset
  // can withdraw an offered spawn.

  always_comb begin
    count_inc   = SpawnCount + 16'd1;
    level_up    = (SPAWNS_PER_LVL == 1) ? 1'b1 : (count_inc[LVL_BITS-1:0] == '0);
    interval_dn = ({1'b0, Interval} >= FLOOR_PLUS_STEP) ? (Interval - STEP_I) : MIN_I;
    interval_nx = level_up ? interval_dn : Interval;
    level_nx    = (level_up && (Level != 3'd7)) ? (Level + 3'd1) : Level;
  end

  // Never repeat the previous lane: bump to the neighbouring lane on a collision.
  always_comb begin
    lane_raw = Rand[1:0];
    lane_sel = (lane_raw == last_lane) ? (lane_raw + 2'd1) : lane_raw;
    mask_sel = 4'b0001 << lane_sel;
`ifdef DOUBLE_NOTE_EN
    if ((Level >= 3'd3) && (Rand[9:7] == 3'b111)) begin
      mask_sel = mask_sel | (4'b0001 << (lane_sel + 2'd2));
    end
`endif
  end

`ifdef DOUBLE_NOTE_EN
  logic unused_rand_bits;
  assign unused_rand_bits = ^Rand[6:2];
`else
  logic unused_rand_bits;
  assign unused_rand_bits = ^Rand[9:2];
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      SpawnValid <= 1'b0;
      SpawnMask  <= 4'b0000;
      Playing    <= 1'b0;
      Level      <= 3'd0;
      Interval   <= BASE_I;
      SpawnCount <= 16'd0;
      countdown  <= 8'd0;
      last_lane  <= 2'd0;
    end else if (Stop) begin
      // Abort drops any pending spawn; score-related state survives until the next Start.
      state      <= S_IDLE;
      SpawnValid <= 1'b0;
      SpawnMask  <= 4'b0000;
      Playing    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state      <= S_WAIT;
            Playing    <= 1'b1;
            Level      <= 3'd0;
            Interval   <= BASE_I;
            SpawnCount <= 16'd0;
            countdown  <= BASE_I;
          end
        end
        S_WAIT: begin
          if (Tick) begin
            if (countdown == 8'd1) begin
              state      <= S_ISSUE;
              SpawnValid <= 1'b1;
              SpawnMask  <= mask_sel;
              last_lane  <= lane_sel;
              countdown  <= 8'd0;
            end else begin
              countdown <= countdown - 8'd1;
            end
          end
        end
        S_ISSUE: begin
          if (SpawnReady) begin
            state      <= S_WAIT;
            SpawnValid <= 1'b0;
            SpawnMask  <= 4'b0000;
            SpawnCount <= count_inc;
            Level      <= level_nx;
            Interval   <= interval_nx;
            countdown  <= interval_nx;
          end
        end
        default: begin
          state      <= S_IDLE;
          SpawnValid <= 1'b0;
          SpawnMask  <= 4'b0000;
          Playing    <= 1'b0;
        end
      endcase
    end
  end

endmodule
